axi_burst_ctrl: RTL and testbench
=================================

// Module: axi_burst_ctrl
// PURPOSE
//  Command-driven AXI4 burst sequencer that sits in front of axi_ram.
//  It turns one {write/read, addr, len} command into a legal AXI4 INCR burst on the m_axi_* side.
//  Write data is streamed in and read data is streamed out, and one completion per command reports the merged response.
//  It replaces bench-side VIP calls when the RAM is driven from RTL.
// PARAMETERS
//  ADDR_WIDTH  12             byte address width, matches the axi_ram ADDR_WIDTH
//  DATA_WIDTH  32             AXI data width (bits)
//  STRB_WIDTH  DATA_WIDTH/8   AXI strobe width (bytes per beat)
// PORTS
//  clk            in   1           clock, all logic posedge
//  rst            in   1           synchronous reset, active-high
//  cmd_valid/ready in/out 1        command handshake; cmd_ready=1 only in IDLE
//  cmd_write      in   1           1=write burst, 0=read burst
//  cmd_addr       in   ADDR_WIDTH  start byte address
//  cmd_len        in   8           beats-1 (AXI len encoding)
//  wr_data/valid  in   DATA_WIDTH/1  write beat stream (all strobes set)
//  wr_ready       out  1           write beat accepted
//  rd_data/valid  out  DATA_WIDTH/1  read beat stream
//  rd_ready       in   1           read sink ready
//  done_valid     out  1           one-cycle completion pulse, no backpressure
//  done_resp      out  2           merged response (OKAY/EXOKAY/SLVERR/DECERR)
//  m_axi_aw*      out  addr,len,size,burst,lock,cache,prot,valid; in awready
//  m_axi_w*       out  data,strb,last,valid; in wready
//  m_axi_b*       in   bresp,bvalid; out bready
//  m_axi_ar*      out  addr,len,size,burst,lock,cache,prot,valid; in arready
//  m_axi_r*       in   rdata,rresp,rlast,rvalid; out rready
// BEHAVIOUR
//  Reset: state=IDLE. cmd_ready=1. Every *valid/*ready output=0 except cmd_ready. done_resp=OKAY. Beat counter=0.
//  Constants: size=$clog2(STRB_WIDTH); burst=INCR; lock, cache and prot=0; wstrb=all ones.
//  FSM: IDLE -> {AW,AR} -> {WDATA,RDATA} -> {BRESP} -> DONE -> IDLE.
//  IDLE: on cmd_valid&&cmd_ready, latch cmd_*.
//   -If the command is illegal, go straight to DONE with resp=SLVERR and issue no AXI traffic.
//   -A command is illegal if addr is not STRB-aligned, or if addr[11:0]+(len+1)*STRB_WIDTH > 4096 (crosses 4KB).
//  AW/AR: *valid is registered high the cycle after accept.
//   -addr and len stay stable until *ready; the handshake moves to WDATA/RDATA.
//   -AW precedes W; there is no early W.
//  WDATA: m_axi_wvalid=wr_valid, wr_ready=m_axi_wready, wdata=wr_data (combinational).
//   -wlast=(beat_cnt==len). beat_cnt++ on each W handshake.
//   -The last handshake moves to BRESP.
//  BRESP: bready=1; on bvalid latch bresp and go to DONE.
//  RDATA: rd_valid=m_axi_rvalid, m_axi_rready=rd_ready, rd_data=rdata (combinational).
//   -done_resp accumulates as the max(rresp) seen over the burst.
//   -The rlast handshake moves to DONE.
//   -If rlast arrives on a beat other than len (early, or still missing at beat len), resp is forced to SLVERR.
//   -An early rlast ends the burst immediately.
//  DONE: done_valid=1 for exactly 1 cycle, then IDLE; cmd_ready returns the next cycle.
//  Latency: with zero-wait slave and source, cmd accept -> done_valid for a write is len+5 cycles minimum.
//  Boundaries:
//   -len=0 gives a single beat with wlast/rlast on beat 0.
//   -len=255 is legal if it stays within 4KB.
//   -cmd_valid outside IDLE is ignored.
//   -rst mid-burst returns to IDLE next edge and drops all valids; the slave must be reset together.
// STRUCTURE
//  axi_ctrl_pkg (shared): axi_resp_t, axi_burst_t, axi_size_t enums.
//  axi_ctrl_pkg also holds ctrl_state_t and function cross_4k(addr,len,strb).
//  Single module; no sub-module is warranted.
// TESTING
//  1 wr 0x100 len2 {deadbeef,c0decafe,babeb00b} -> 3 W beats, wlast on beat 2, done OKAY.
//    Then rd 0x100 len2 -> same 3 words, done OKAY.
//  2 wr_valid low 4 cycles between beats -> wvalid follows, no extra beats, RAM contents correct.
//  3 rd 0x100 len2 with rd_ready toggling 1/0 -> rready mirrors rd_ready, 3 beats in order, one done pulse.
//  4 wr 0xFF8 len3 (crosses 4KB) -> awvalid never asserts, done_valid 2 cycles after accept, resp=SLVERR.
//    Also wr 0x102 (unaligned) -> same SLVERR result.
//  5 rst high during WDATA beat 1 of len7 -> next cycle all valids=0, cmd_ready=1.
//    A following wr/rd at 0x200 completes OKAY.
//  6 len0 at 0x000 and len255 at 0x000 -> 1 and 256 beats, last flags correct, data readback matches.

Source files
------------

// File: rtl/axi_ctrl_pkg.sv
// axi_ctrl_pkg: AXI response/burst/size enums, controller states and the 4KB-crossing check
package axi_ctrl_pkg;
  typedef enum logic [1:0] {RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR} axi_resp_t;
  typedef enum logic [1:0] {BURST_FIXED, BURST_INCR, BURST_WRAP} axi_burst_t;
  typedef enum logic [2:0] {SIZE_1B, SIZE_2B, SIZE_4B, SIZE_8B, SIZE_16B, SIZE_32B, SIZE_64B, SIZE_128B} axi_size_t;
  typedef enum logic [2:0] {S_IDLE, S_AW, S_AR, S_WDATA, S_RDATA, S_BRESP, S_DONE} ctrl_state_t;
  function automatic logic cross_4k(input logic [11:0] addr, input logic [7:0] len, input int strb);
    return (32'(addr) + (32'(len) + 32'd1) * 32'(strb)) > 32'd4096;
  endfunction
endpackage

// File: rtl/axi_burst_ctrl.sv
// axi_burst_ctrl: turns {write/read, addr, len} commands into AXI4 INCR bursts with streamed data and one merged completion
module axi_burst_ctrl
  import axi_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  done_valid,
  output logic [1:0]            done_resp,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);
  localparam axi_size_t SIZE = axi_size_t'($clog2(STRB_WIDTH));
  ctrl_state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0] len_q, len_d, beat_q, beat_d;
  axi_resp_t resp_q, resp_d, r_max;
  logic awvalid_q, awvalid_d, arvalid_q, arvalid_d, bready_q, bready_d;
  logic done_q, done_d, cmd_ready_q, cmd_ready_d;
  logic illegal, w_hs, r_hs, r_last_bad;
  assign illegal = ((32'(cmd_addr) % 32'(STRB_WIDTH)) != 32'd0) || cross_4k(12'(cmd_addr), cmd_len, STRB_WIDTH);
  assign w_hs = state_q == S_WDATA && wr_valid && m_axi_wready;
  assign r_hs = state_q == S_RDATA && m_axi_rvalid && rd_ready;
  assign r_last_bad = m_axi_rlast != (beat_q == len_q);
  assign r_max = axi_resp_t'((m_axi_rresp > resp_q) ? m_axi_rresp : resp_q);
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    len_d = len_q;
    beat_d = beat_q;
    resp_d = resp_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        addr_d = cmd_addr;
        len_d = cmd_len;
        beat_d = 8'd0;
        resp_d = illegal ? RESP_SLVERR : RESP_OKAY;
        state_d = illegal ? S_DONE : cmd_write ? S_AW : S_AR;
      end
      S_AW: state_d = m_axi_awready ? S_WDATA : S_AW;
      S_AR: state_d = m_axi_arready ? S_RDATA : S_AR;
      S_WDATA: if (w_hs) begin
        beat_d = beat_q + 8'd1;
        state_d = (beat_q == len_q) ? S_BRESP : S_WDATA;
      end
      S_BRESP: if (m_axi_bvalid) begin
        resp_d = axi_resp_t'(m_axi_bresp);
        state_d = S_DONE;
      end
      S_RDATA: if (r_hs) begin
        beat_d = beat_q + 8'd1;
        resp_d = r_last_bad ? RESP_SLVERR : r_max;
        state_d = m_axi_rlast ? S_DONE : S_RDATA;
      end
      default: state_d = S_IDLE;
    endcase
    awvalid_d = state_d == S_AW;
    arvalid_d = state_d == S_AR;
    bready_d = state_d == S_BRESP;
    done_d = state_d == S_DONE;
    cmd_ready_d = state_d == S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      len_q <= 8'd0;
      beat_q <= 8'd0;
      resp_q <= RESP_OKAY;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q <= 1'b0;
      done_q <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      len_q <= len_d;
      beat_q <= beat_d;
      resp_q <= resp_d;
      awvalid_q <= awvalid_d;
      arvalid_q <= arvalid_d;
      bready_q <= bready_d;
      done_q <= done_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end
  assign cmd_ready = cmd_ready_q;
  assign done_valid = done_q;
  assign done_resp = resp_q;
  assign m_axi_awaddr = addr_q;
  assign m_axi_awlen = len_q;
  assign m_axi_awsize = SIZE;
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awlock = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot = 3'd0;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_arlen = len_q;
  assign m_axi_arsize = SIZE;
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arlock = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot = 3'd0;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_wdata = wr_data;
  assign m_axi_wstrb = '1;
  assign m_axi_wlast = beat_q == len_q;
  assign m_axi_wvalid = state_q == S_WDATA && wr_valid;
  assign wr_ready = state_q == S_WDATA && m_axi_wready;
  assign m_axi_bready = bready_q;
  assign rd_data = m_axi_rdata;
  assign rd_valid = state_q == S_RDATA && m_axi_rvalid;
  assign m_axi_rready = state_q == S_RDATA && rd_ready;
endmodule

// File: tb/tb_axi_burst_ctrl.sv
// tb_axi_burst_ctrl: directed and random commands against a RAM-backed AXI slave, checked by a word-level memory model
module tb_axi_burst_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [7:0] cmd_len = '0;
  logic [31:0] wr_data = '0, rd_data;
  logic wr_valid = 1'b0, wr_ready, rd_valid, rd_ready = 1'b0, done_valid;
  logic [1:0] done_resp;
  logic [11:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0] m_axi_awlen, m_axi_arlen;
  logic [2:0] m_axi_awsize, m_axi_awprot, m_axi_arsize, m_axi_arprot;
  logic [1:0] m_axi_awburst, m_axi_arburst, m_axi_rresp;
  logic [1:0] m_axi_bresp = '0;
  logic [3:0] m_axi_awcache, m_axi_arcache, m_axi_wstrb;
  logic m_axi_awlock, m_axi_awvalid, m_axi_arlock, m_axi_arvalid;
  logic m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0, m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic m_axi_wlast, m_axi_wvalid, m_axi_bready, m_axi_rlast, m_axi_rready;

  axi_burst_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .STRB_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .done_valid(done_valid), .done_resp(done_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  bit [31:0] ram [0:1023];
  bit [31:0] exp_mem [0:1023];
  logic [31:0] fixed_q [$];
  logic s_wact = 1'b0, s_ract = 1'b0;
  logic [9:0] s_widx = '0, s_ridx = '0;
  logic [7:0] s_rbeat = '0;
  int s_rlast_at = 0;
  logic [1:0] inj_bresp = 2'd0, inj_rresp_val = 2'd0;
  int inj_rresp_beat = -1, inj_rlast_at = -1;
  bit stall = 1'b0;
  int n_assert = 0, n_fail = 0;

  function automatic logic rdy();
    return !stall || ($urandom_range(0, 2) != 0);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_axi_awready <= 1'b0;
      m_axi_wready <= 1'b0;
      m_axi_bvalid <= 1'b0;
      s_wact <= 1'b0;
    end else begin
      m_axi_awready <= !s_wact && !m_axi_bvalid && rdy();
      m_axi_wready <= rdy();
      if (m_axi_awvalid && m_axi_awready) begin
        s_wact <= 1'b1;
        s_widx <= m_axi_awaddr[11:2];
        m_axi_awready <= 1'b0;
      end
      if (m_axi_wvalid && m_axi_wready && s_wact) begin
        ram[s_widx] <= m_axi_wdata;
        s_widx <= s_widx + 10'd1;
        if (m_axi_wlast) begin
          s_wact <= 1'b0;
          m_axi_bvalid <= 1'b1;
          m_axi_bresp <= inj_bresp;
        end
      end
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
    end
  end

  assign m_axi_rdata = ram[s_ridx];
  assign m_axi_rlast = int'(s_rbeat) == s_rlast_at;
  assign m_axi_rresp = (int'(s_rbeat) == inj_rresp_beat) ? inj_rresp_val : 2'd0;

  always @(posedge clk) begin
    if (rst) begin
      m_axi_arready <= 1'b0;
      m_axi_rvalid <= 1'b0;
      s_ract <= 1'b0;
    end else begin
      m_axi_arready <= !s_ract && rdy();
      if (m_axi_arvalid && m_axi_arready) begin
        s_ract <= 1'b1;
        s_ridx <= m_axi_araddr[11:2];
        s_rbeat <= 8'd0;
        s_rlast_at <= (inj_rlast_at >= 0) ? inj_rlast_at : int'(m_axi_arlen);
        m_axi_arready <= 1'b0;
      end
      if (m_axi_rvalid && m_axi_rready) begin
        s_ridx <= s_ridx + 10'd1;
        s_rbeat <= s_rbeat + 8'd1;
        if (m_axi_rlast) begin
          s_ract <= 1'b0;
          m_axi_rvalid <= 1'b0;
        end else m_axi_rvalid <= rdy();
      end else if (s_ract && !m_axi_rvalid) m_axi_rvalid <= rdy();
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] valids();
    return {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rd_valid, wr_ready, done_valid};
  endfunction

  task automatic run_cmd(input bit wr, input logic [11:0] addr, input int len, input int gap,
                         input bit rtoggle, input int abort, input bit zero_wait);
    logic [31:0] data [$];
    logic [31:0] got [$];
    bit lasts [$];
    int wi, gapc, done_at, dones, wv_bad, rr_bad, strb_bad, seen_axi, nb, bad_data, bad_last;
    logic [1:0] resp, exp_resp;
    logic [31:0] a_hdr;
    logic [9:0] a_ctl;
    bit legal;
    string t;
    wi = 0; gapc = 0; done_at = 0; dones = 0; wv_bad = 0; rr_bad = 0; strb_bad = 0; seen_axi = 0;
    bad_data = 0; bad_last = 0; resp = 2'd0; a_hdr = '1; a_ctl = '1;
    t = $sformatf("%s@%0h/%0d", wr ? "wr" : "rd", addr, len);
    legal = (addr % 4 == 0) && (32'(addr) + 32'((len + 1) * 4) <= 32'd4096);
    for (int i = 0; i <= len; i++) data.push_back(fixed_q.size() > i ? fixed_q[i] : $urandom);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = 8'(len);
    #1 chk({t, " cmd_ready"}, 64'(cmd_ready), 64'd1);
    for (int cyc = 1; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        cmd_addr = 12'($urandom); cmd_len = 8'($urandom); cmd_write = 1'($urandom);
      end
      if (done_valid) begin
        dones++;
        resp = done_resp;
        if (done_at == 0) done_at = cyc + 1;
        cmd_valid = 1'b0;
      end
      if (done_at != 0 && cyc + 1 > done_at) break;
      if (wr) begin
        if (gapc > 0) begin wr_valid = 1'b0; gapc--; end
        else if (wi <= len) begin wr_valid = 1'b1; wr_data = data[wi]; end
        else wr_valid = 1'b0;
      end
      rd_ready = rtoggle ? ((cyc % 2) == 1) : 1'b1;
      #1;
      if (abort >= 0 && wi == abort && m_axi_wvalid) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk({t, " rst_valids"}, 64'(valids()), 64'd0);
        chk({t, " rst_cmd_ready"}, 64'(cmd_ready), 64'd1);
        rst = 1'b0; wr_valid = 1'b0; cmd_valid = 1'b0;
        for (int i = 0; i < wi; i++) exp_mem[addr[11:2] + 10'(i)] = data[i];
        return;
      end
      if (m_axi_awvalid || m_axi_arvalid) seen_axi = 1;
      if (m_axi_awvalid && m_axi_awready)
        begin a_hdr = {m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, 7'd0}; a_ctl = {m_axi_awlock, m_axi_awcache, m_axi_awprot, 2'd0}; end
      if (m_axi_arvalid && m_axi_arready)
        begin a_hdr = {m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, 7'd0}; a_ctl = {m_axi_arlock, m_axi_arcache, m_axi_arprot, 2'd0}; end
      if (m_axi_wvalid && !wr_valid) wv_bad++;
      if ((m_axi_rready && !rd_ready) || ((rd_valid && rd_ready) != (m_axi_rvalid && m_axi_rready))) rr_bad++;
      if (wr_valid && wr_ready) begin
        got.push_back(m_axi_wdata); lasts.push_back(m_axi_wlast);
        if (m_axi_wstrb != 4'hF) strb_bad++;
        wi++; gapc = gap;
      end
      if (rd_valid && rd_ready) got.push_back(rd_data);
    end
    wr_valid = 1'b0; cmd_valid = 1'b0;
    nb = !legal ? 0 : (!wr && inj_rlast_at >= 0 && inj_rlast_at < len) ? inj_rlast_at + 1 : len + 1;
    exp_resp = !legal ? 2'd2 : wr ? inj_bresp : (nb != len + 1) ? 2'd2 :
               (inj_rresp_beat >= 0 && inj_rresp_beat < nb) ? inj_rresp_val : 2'd0;
    chk({t, " done_count"}, 64'(dones), 64'd1);
    chk({t, " done_resp"}, 64'(resp), 64'(exp_resp));
    chk({t, " beats"}, 64'(got.size()), 64'(nb));
    for (int i = 0; i < got.size(); i++) begin
      if (got[i] !== (wr ? data[i] : exp_mem[addr[11:2] + 10'(i)])) bad_data++;
      if (wr && lasts[i] != (i == len)) bad_last++;
    end
    chk({t, " data_mismatches"}, 64'(bad_data), 64'd0);
    if (wr) chk({t, " wlast_mismatches"}, 64'(bad_last), 64'd0);
    if (wr) chk({t, " wvalid_follow"}, 64'({wv_bad, strb_bad}), 64'd0);
    if (!wr) chk({t, " rready_mirror"}, 64'(rr_bad), 64'd0);
    if (legal) chk({t, " addr_phase"}, {a_hdr, 22'd0, a_ctl}, {addr, 8'(len), 3'd2, 2'd1, 7'd0, 22'd0, 10'd0});
    if (!legal) chk({t, " illegal_no_axi_latency"}, 64'({seen_axi, done_at}), 64'({32'd0, 32'd2}));
    if (legal && wr && zero_wait) chk({t, " latency"}, 64'(done_at), 64'(len + 5));
    if (legal && wr) for (int i = 0; i <= len; i++) exp_mem[addr[11:2] + 10'(i)] = data[i];
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset valids", 64'(valids()), 64'd0);
    chk("reset cmd_ready/done_resp", 64'({cmd_ready, done_resp}), 64'd4);
    rst = 1'b0;
    fixed_q = '{32'hdeadbeef, 32'hc0decafe, 32'hbabeb00b};
    run_cmd(1, 12'h100, 2, 0, 0, -1, 1);
    fixed_q.delete();
    run_cmd(0, 12'h100, 2, 0, 0, -1, 1);
    run_cmd(1, 12'h140, 3, 4, 0, -1, 0);
    run_cmd(0, 12'h140, 3, 0, 0, -1, 0);
    run_cmd(0, 12'h100, 2, 0, 1, -1, 0);
    run_cmd(1, 12'hFF8, 3, 0, 0, -1, 0);
    run_cmd(1, 12'h102, 0, 0, 0, -1, 0);
    run_cmd(0, 12'hC04, 255, 0, 0, -1, 0);
    run_cmd(1, 12'h300, 7, 0, 0, 1, 0);
    run_cmd(1, 12'h200, 3, 0, 0, -1, 1);
    run_cmd(0, 12'h200, 3, 0, 0, -1, 0);
    run_cmd(0, 12'h300, 0, 0, 0, -1, 0);
    run_cmd(1, 12'h000, 0, 0, 0, -1, 1);
    run_cmd(0, 12'h000, 0, 0, 0, -1, 0);
    run_cmd(1, 12'h000, 255, 0, 0, -1, 1);
    run_cmd(0, 12'h000, 255, 0, 1, -1, 0);
    run_cmd(1, 12'hC00, 255, 0, 0, -1, 0);
    run_cmd(0, 12'hC00, 255, 0, 0, -1, 0);
    inj_bresp = 2'd2;
    run_cmd(1, 12'h400, 1, 0, 0, -1, 0);
    inj_bresp = 2'd0;
    inj_rresp_beat = 1; inj_rresp_val = 2'd3;
    run_cmd(0, 12'h400, 3, 0, 0, -1, 0);
    inj_rresp_val = 2'd1;
    run_cmd(0, 12'h400, 3, 0, 0, -1, 0);
    inj_rresp_beat = -1; inj_rlast_at = 1;
    run_cmd(0, 12'h000, 3, 0, 0, -1, 0);
    inj_rlast_at = -1;
    stall = 1'b1;
    for (int k = 0; k < 30; k++) begin
      logic [11:0] a;
      int l;
      a = 12'($urandom_range(0, 1023) * 4);
      if ($urandom_range(0, 7) == 0) a = a + 12'($urandom_range(1, 3));
      l = ($urandom_range(0, 9) == 0) ? $urandom_range(200, 255) : $urandom_range(0, 20);
      if ($urandom_range(0, 3) == 0) begin
        inj_rresp_beat = $urandom_range(0, 3);
        inj_rresp_val = 2'($urandom_range(1, 3));
      end
      run_cmd(1'($urandom_range(0, 1)), a, l, $urandom_range(0, 2), 1'($urandom_range(0, 1)), -1, 0);
      inj_rresp_beat = -1;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
